// File: rtl/riscv_v_pkg.sv
// -----------------------------------------------------------------------------
// riscv_v_pkg
//
// Purpose : shared constants and types for the vector datapath blocks.
//   RISCV_V_DATA_WIDTH  - width of a full vector data word
//   RISCV_V_CHUNK_WIDTH - width of the narrow chunks fed to scalar/store paths
//   ser_state_t         - state encoding of the vector-to-chunk serializer
// Ports   : none (package)
// -----------------------------------------------------------------------------
package riscv_v_pkg;

   localparam int RISCV_V_DATA_WIDTH  = 128;
   localparam int RISCV_V_CHUNK_WIDTH = 32;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

endpackage : riscv_v_pkg

// File: rtl/riscv_v_stage_serializer.sv
// -----------------------------------------------------------------------------
// riscv_v_stage_serializer
//
// Purpose : takes one wide vector word from the vector pipeline register and
//           emits it as CHUNK_WIDTH-wide chunks, least-significant chunk first,
//           with valid/ready on both sides and a synchronous flush.
//
// Ports   :
//   clk            in   clock
//   rst            in   asynchronous reset, active-high
//   flush          in   synchronous flush, drops any in-progress word
//   in_valid       in   input word valid
//   in_ready       out  a word can be accepted this cycle
//   in_data        in   DATA_WIDTH vector word
//   in_num_chunks  in   number of chunks to emit (clamped to NUM_CHUNKS)
//   out_valid      out  chunk valid
//   out_ready      in   sink accepts chunk
//   out_data       out  current chunk
//   out_idx        out  index of the current chunk within its word
//   out_first      out  current chunk is index 0
//   out_last       out  current chunk is the final one of the word
//   busy           out  a word is held (SEND state)
// -----------------------------------------------------------------------------
module riscv_v_stage_serializer
   import riscv_v_pkg::*;
#(
   parameter int DATA_WIDTH  = RISCV_V_DATA_WIDTH,
   parameter int CHUNK_WIDTH = RISCV_V_CHUNK_WIDTH,
   localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH,
   localparam int CNT_W      = $clog2(NUM_CHUNKS) + 1,
   localparam int IDX_W      = (CNT_W - 1 < 1) ? 1 : CNT_W - 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [CNT_W-1:0]       in_num_chunks,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CHUNK_WIDTH-1:0] out_data,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_first,
   output logic                   out_last,
   output logic                   busy
);

   // The word must split into a whole number of chunks.
   if ((DATA_WIDTH % CHUNK_WIDTH) != 0 || DATA_WIDTH < CHUNK_WIDTH) begin : g_bad_width
      $error("riscv_v_stage_serializer: DATA_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
   end

   ser_state_t              r_state;
   logic [DATA_WIDTH-1:0]   r_word;
   logic [CNT_W-1:0]        r_num;
   logic [IDX_W-1:0]        r_idx;

   logic                    w_send;
   logic                    w_last;
   logic                    w_out_xfer;
   logic                    w_accept;
   logic [CNT_W-1:0]        w_n;

   // Requested length saturated to the number of chunks in a word.
   assign w_n = (in_num_chunks > CNT_W'(NUM_CHUNKS)) ? CNT_W'(NUM_CHUNKS) : in_num_chunks;

   assign w_send     = (r_state == SER_SEND);
   assign w_last     = w_send && (CNT_W'(r_idx) == (r_num - CNT_W'(1)));
   assign w_out_xfer = w_send && out_ready;

   // A new word slips in during the final transfer of the current one, which
   // is what makes back-to-back words bubble-free. Flush blocks everything.
   assign in_ready = !flush && (!w_send || (out_ready && w_last));
   assign w_accept = in_valid && in_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would chain updates within one edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= SER_IDLE;
         // NOTE: the held word is reset as well so out_data reads zero out of
         // reset; this is a plain register, not a RAM, so a reset is cheap.
         r_word  <= '0;
         r_num   <= '0;
         r_idx   <= '0;
      end else if (flush) begin
         // The held word is intentionally kept; only control state is dropped.
         r_state <= SER_IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            SER_IDLE: begin
               if (w_accept && (w_n != '0)) begin
                  r_word  <= in_data;
                  r_num   <= w_n;
                  r_idx   <= '0;
                  r_state <= SER_SEND;
               end
            end
            SER_SEND: begin
               if (w_out_xfer) begin
                  if (!w_last) begin
                     r_idx <= r_idx + IDX_W'(1);
                  end else if (w_accept && (w_n != '0)) begin
                     r_word  <= in_data;
                     r_num   <= w_n;
                     r_idx   <= '0;
                  end else begin
                     // Either nothing waiting, or a zero-length word that is
                     // swallowed without output.
                     r_state <= SER_IDLE;
                  end
               end
            end
            default: r_state <= SER_IDLE;
         endcase
      end
   end

   assign out_valid = w_send;
   assign busy      = w_send;
   assign out_data  = r_word[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign out_idx   = r_idx;
   assign out_first = w_send && (r_idx == '0);
   assign out_last  = w_last;

endmodule : riscv_v_stage_serializer
